button_conditioner: RTL and testbench

BUTTON_CONDITIONER -- requirements
Module: button_conditioner

---
 rtl/button_conditioner.sv | 129 ++++++++++++
 tb/tb_button_conditioner.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/button_conditioner.sv
// Four-button front end: 2-flop synchronizers, per-bit debounce, and a
// one-hot command strobe with press-and-hold auto-repeat.
module button_conditioner #(
    parameter int DB_CYCLES  = 50000,
    parameter int RPT_DELAY  = 25000000,
    parameter int RPT_PERIOD = 5000000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] btn_raw,
    output logic [3:0] btn_pulse,
    output logic [3:0] btn_level
);

    // state  | meaning
    // IDLE   | no button being tracked for repeat
    // HOLD   | pressed button pulsed, waiting RPT_DELAY for first repeat
    // REPEAT | repeating held button every RPT_PERIOD
    typedef enum logic [1:0] {IDLE, HOLD, REPEAT} state_t;

    localparam int DB_W    = $clog2(DB_CYCLES + 1);
    localparam int RPT_MAX = (RPT_DELAY > RPT_PERIOD) ? RPT_DELAY : RPT_PERIOD;
    localparam int RPT_W   = $clog2(RPT_MAX + 1);

    logic [3:0]      sync1, sync2;
    logic [DB_W-1:0] db_cnt [4];
    logic [3:0]      level_d;
    logic [3:0]      press, release_ev;
    logic [1:0]      press_idx;

    state_t           state, state_nxt;
    logic [1:0]       held_idx, held_nxt;
    logic [RPT_W-1:0] rpt_cnt, cnt_nxt;
    logic [3:0]       pulse_nxt;
    logic             expire;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= btn_raw;
            sync2 <= sync1;
        end
    end

    // Level flips on the DB_CYCLES-th consecutive disagreeing sample.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            btn_level <= '0;
            level_d   <= '0;
            for (int i = 0; i < 4; i++) db_cnt[i] <= '0;
        end else begin
            level_d <= btn_level;
            for (int i = 0; i < 4; i++) begin
                if (sync2[i] == btn_level[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DB_W'(DB_CYCLES - 1)) begin
                    btn_level[i] <= sync2[i];
                    db_cnt[i]    <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + 1'b1;
                end
            end
        end
    end

    assign press      = btn_level & ~level_d;
    assign release_ev = ~btn_level & level_d;
    assign expire     = (rpt_cnt == RPT_W'(1));

    always_comb begin
        press_idx = '0;
        for (int i = 3; i >= 0; i--) begin
            if (press[i]) press_idx = 2'(i);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            held_idx  <= '0;
            rpt_cnt   <= '0;
            btn_pulse <= '0;
        end else begin
            state     <= state_nxt;
            held_idx  <= held_nxt;
            rpt_cnt   <= cnt_nxt;
            btn_pulse <= pulse_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (|press) state_nxt = HOLD;
            end
            HOLD, REPEAT: begin
                if (|press)                    state_nxt = HOLD;
                else if (release_ev[held_idx]) state_nxt = IDLE;
                else if (expire)               state_nxt = REPEAT;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // A new press always wins; a held-bit release beats a same-cycle expiry.
    always_comb begin
        pulse_nxt = '0;
        held_nxt  = held_idx;
        cnt_nxt   = rpt_cnt;
        if (|press) begin
            pulse_nxt = 4'(1) << press_idx;
            held_nxt  = press_idx;
            cnt_nxt   = RPT_W'(RPT_DELAY);
        end else if (state != IDLE) begin
            if (release_ev[held_idx]) begin
                cnt_nxt = '0;
            end else if (expire) begin
                pulse_nxt = 4'(1) << held_idx;
                cnt_nxt   = RPT_W'(RPT_PERIOD);
            end else begin
                cnt_nxt = rpt_cnt - 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_button_conditioner.sv
// Self-checking bench for button_conditioner: directed scenarios plus random
// button activity, compared each cycle against an edge-counting reference.
module tb_button_conditioner;

    localparam int DB  = 4;
    localparam int DLY = 10;
    localparam int PER = 3;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] btn_raw = '0;
    logic [3:0] btn_pulse, btn_level;

    int n_checks = 0;
    int n_fails  = 0;

    button_conditioner #(.DB_CYCLES(DB), .RPT_DELAY(DLY), .RPT_PERIOD(PER)) dut (
        .clk(clk), .rst_n(rst_n), .btn_raw(btn_raw),
        .btn_pulse(btn_pulse), .btn_level(btn_level)
    );

    always #5 clk = ~clk;

    // Reference: levels from a run-length of disagreeing samples, repeat
    // schedule as absolute edge numbers of the next due pulse.
    logic [3:0] m_s1, m_s2, m_lvl, m_lvl_d, m_pulse;
    int         m_run [4];
    bit         m_active;
    int         m_held;
    longint     m_edge, m_fire;

    task automatic model_reset();
        m_s1 = '0; m_s2 = '0; m_lvl = '0; m_lvl_d = '0; m_pulse = '0;
        for (int i = 0; i < 4; i++) m_run[i] = 0;
        m_active = 0; m_held = 0; m_edge = 0; m_fire = 0;
    endtask

    task automatic model_edge(input logic [3:0] raw);
        logic [3:0] pr, rl;
        pr = m_lvl & ~m_lvl_d;
        rl = ~m_lvl & m_lvl_d;
        m_edge++;
        m_pulse = '0;
        if (pr != 0) begin
            for (int i = 3; i >= 0; i--) if (pr[i]) m_held = i;
            m_pulse[m_held] = 1'b1;
            m_active = 1;
            m_fire = m_edge + DLY;
        end else if (m_active && rl[m_held]) begin
            m_active = 0;
        end else if (m_active && m_edge == m_fire) begin
            m_pulse[m_held] = 1'b1;
            m_fire = m_edge + PER;
        end
        m_lvl_d = m_lvl;
        for (int i = 0; i < 4; i++) begin
            if (m_s2[i] != m_lvl[i]) begin
                m_run[i]++;
                if (m_run[i] == DB) begin
                    m_lvl[i] = m_s2[i];
                    m_run[i] = 0;
                end
            end else begin
                m_run[i] = 0;
            end
        end
        m_s2 = m_s1;
        m_s1 = raw;
    endtask

    task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %b expected %b at edge %0d", tag, obs, exp, m_edge);
        end
    endtask

    task automatic step(input logic [3:0] raw);
        btn_raw = raw;
        @(posedge clk);
        model_edge(raw);
        #1;
        check("pulse", btn_pulse, m_pulse);
        check("level", btn_level, m_lvl);
        n_checks++;
        assert ($countones(btn_pulse) <= 1) else begin
            n_fails++;
            $error("FAIL onehot: observed %b expected at most one bit", btn_pulse);
        end
    endtask

    // Assert reset for two edges; outputs must clear before any clock edge.
    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        check("async_rst_pulse", btn_pulse, 4'b0000);
        check("async_rst_level", btn_level, 4'b0000);
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        rst_n = 1'b1;
    endtask

    function automatic logic [3:0] exp_027(input int k);
        if (k == 7 || k == 17 || k == 20 || k == 23 || k == 26 || k == 29) return 4'b0100;
        return 4'b0000;
    endfunction

    initial begin
        logic [3:0] r;
        int k;
        model_reset();
        #12;
        check("reset_pulse", btn_pulse, 4'b0000);
        check("reset_level", btn_level, 4'b0000);
        rst_n = 1'b1;

        // Single press, released early: one pulse at edge 7, none after.
        for (k = 1; k <= 30; k++) begin
            step((k <= 8) ? 4'b0001 : 4'b0000);
            if (k == 6) check("d025_level6", btn_level, 4'b0001);
            if (k == 7) check("d025_pulse7", btn_pulse, 4'b0001);
            if (k > 7)  check("d025_nopulse", btn_pulse, 4'b0000);
        end

        // Bouncing bit 1 never qualifies.
        do_reset();
        for (k = 0; k < 6; k++) begin
            step((k % 2 == 0) ? 4'b0010 : 4'b0000);
            check("d026_pulse", btn_pulse, 4'b0000);
            check("d026_level", btn_level, 4'b0000);
        end
        for (k = 0; k < 15; k++) begin
            step((k < 3) ? 4'b0010 : 4'b0000);
            check("d026_pulse", btn_pulse, 4'b0000);
            check("d026_level", btn_level, 4'b0000);
        end

        // Hold bit 2: initial pulse then auto-repeat cadence, then release.
        do_reset();
        for (k = 1; k <= 45; k++) begin
            step((k <= 30) ? 4'b0100 : 4'b0000);
            if (k <= 30) check("d027_sched", btn_pulse, exp_027(k));
            if (k > 36)  check("d027_stop", btn_pulse, 4'b0000);
        end

        // Simultaneous press: lowest index wins and repeats alone.
        do_reset();
        for (k = 1; k <= 25; k++) begin
            step(4'b0011);
            if (k == 7) check("d028_pulse7", btn_pulse, 4'b0001);
            if (k > 6)  check("d028_level", btn_level, 4'b0011);
            if (k > 6)  check("d028_no_bit1", {btn_pulse[3:1], 1'b0}, 4'b0000);
        end

        // Bit 0 repeating, bit 3 joins: switch to bit 3 with fresh delay.
        for (k = 1; k <= 30; k++) begin
            step(4'b1001);
            if (k > 6) check("d029_no_bit0", {3'b000, btn_pulse[0]}, 4'b0000);
        end
        for (k = 0; k < 10; k++) step(4'b0000);

        // Reset mid-repeat with bit 2 still held: fresh press after reset.
        do_reset();
        for (k = 0; k < 25; k++) step(4'b0100);
        do_reset();
        for (k = 1; k <= 12; k++) begin
            step(4'b0100);
            if (k == 7) check("d030_pulse7", btn_pulse, 4'b0100);
            if (k < 7)  check("d030_quiet", btn_pulse, 4'b0000);
        end

        // Random activity: slow presses, occasional bounce bursts and resets.
        do_reset();
        r = '0;
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 11) == 0) r[$urandom_range(0, 3)] ^= 1'b1;
            if ($urandom_range(0, 40) == 0) begin
                for (int b = 0; b < int'($urandom_range(1, 5)); b++)
                    step(r ^ 4'($urandom_range(0, 15)));
            end
            if ($urandom_range(0, 999) == 0) do_reset();
            step(r);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
